// File: rtl/param_seq_detector.sv
// Serial pattern detector: runtime-loadable 1..PATTERN_W bit pattern, overlap/non-overlap, saturating match counter.
// Latency: output_z is registered and pulses for one cycle after the edge that samples the last pattern bit.
// Backpressure: none; input_valid qualifies input_x, and idle cycles hold history and fill.
//
// Ports:
//   clock, reset       : sole clock; synchronous active-high reset, highest priority
//   load               : capture pattern_in / length_in / overlap_in and clear history
//   pattern_in         : right-aligned pattern; bit [len-1] is received first, bit [0] last
//   length_in          : active length; 0 or > PATTERN_W is clamped to PATTERN_W
//   overlap_in         : 1 = overlapping matches, 0 = history restarts after a match
//   count_clear        : clear match_count (a same-cycle match still counts as 1)
//   input_valid/input_x: qualified serial data bit
//   output_z           : registered one-cycle match pulse
//   match_count        : saturating count of matches
module param_seq_detector #(
  parameter int                   PATTERN_W     = 8,
  parameter int                   COUNT_W       = 8,
  parameter logic [PATTERN_W-1:0] RESET_PATTERN = 8'b0001_0011,
  parameter int                   RESET_LEN     = 5,
  parameter logic                 RESET_OVERLAP = 1'b1,
  localparam int                  LEN_W         = $clog2(PATTERN_W + 1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 load,
  input  logic [PATTERN_W-1:0] pattern_in,
  input  logic [LEN_W-1:0]     length_in,
  input  logic                 overlap_in,
  input  logic                 count_clear,
  input  logic                 input_valid,
  input  logic                 input_x,
  output logic                 output_z,
  output logic [COUNT_W-1:0]   match_count
);

  localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(PATTERN_W);

  // Reset length gets the same clamp as a runtime load.
  localparam logic [LEN_W-1:0] RESET_LEN_C =
    (RESET_LEN <= 0 || RESET_LEN > PATTERN_W) ? FULL_LEN : LEN_W'(RESET_LEN);

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
    if (l == '0 || int'(l) > PATTERN_W) begin
      return FULL_LEN;
    end
    return l;
  endfunction

  logic [PATTERN_W-1:0] pat;
  logic [LEN_W-1:0]     len;
  logic                 ovl;
  logic [PATTERN_W-1:0] hist;
  logic [LEN_W-1:0]     fill;

  logic [PATTERN_W-1:0] hist_n;
  logic [LEN_W-1:0]     fill_n;
  logic [PATTERN_W-1:0] mask;
  logic                 pat_hit;
  logic                 match;
  logic [COUNT_W-1:0]   cnt_base;
  logic [COUNT_W-1:0]   cnt_n;

  always_comb begin
    hist_n = {hist[PATTERN_W-2:0], input_x};
    // fill saturates: once the window is full it stays full.
    fill_n = (fill == FULL_LEN) ? fill : fill + LEN_W'(1);

    // Only the low len history bits take part in the compare.
    mask = '0;
    for (int i = 0; i < PATTERN_W; i++) begin
      mask[i] = (i < int'(len));
    end
    pat_hit = (((hist_n ^ pat) & mask) == '0);

    match = input_valid && !load && (fill_n >= len) && pat_hit;

    // Clear first, then count a same-cycle match on top of it.
    cnt_base = count_clear ? '0 : match_count;
    cnt_n    = (match && (cnt_base != '1)) ? cnt_base + COUNT_W'(1) : cnt_base;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pat         <= RESET_PATTERN;
      len         <= RESET_LEN_C;
      ovl         <= RESET_OVERLAP;
      hist        <= '0;
      fill        <= '0;
      output_z    <= 1'b0;
      match_count <= '0;
    end else begin
      match_count <= cnt_n;
      if (load) begin
        pat      <= pattern_in;
        len      <= clamp_len(length_in);
        ovl      <= overlap_in;
        hist     <= '0;
        fill     <= '0;
        output_z <= 1'b0;
      end else if (input_valid) begin
        hist     <= hist_n;
        output_z <= match;
        // Non-overlap mode restarts the fill so the next match needs len fresh bits.
        fill     <= (match && !ovl) ? '0 : fill_n;
      end else begin
        output_z <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_param_seq_detector.sv
// Self-checking bench for param_seq_detector (PATTERN_W = 8, COUNT_W = 2 to reach saturation).
// Directed scenarios are checked against hand-derived constants; the random run is checked
// against a queue-based model of the bits received since the last restart.
module tb_param_seq_detector;

  localparam int PW = 8;
  localparam int CW = 2;
  localparam int LW = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          load = 1'b0;
  logic [PW-1:0] pattern_in = '0;
  logic [LW-1:0] length_in = '0;
  logic          overlap_in = 1'b0;
  logic          count_clear = 1'b0;
  logic          input_valid = 1'b0;
  logic          input_x = 1'b0;
  logic          output_z;
  logic [CW-1:0] match_count;

  param_seq_detector #(.PATTERN_W(PW), .COUNT_W(CW)) dut (
    .clock(clock), .reset(reset), .load(load), .pattern_in(pattern_in),
    .length_in(length_in), .overlap_in(overlap_in), .count_clear(count_clear),
    .input_valid(input_valid), .input_x(input_x), .output_z(output_z),
    .match_count(match_count)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: pattern settings plus the bits received since the last restart.
  logic [PW-1:0] m_pat;
  int            m_len;
  logic          m_ovl;
  bit            q[$];
  logic          exp_z;
  int            exp_cnt;

  // Drive one cycle of inputs, advance the model across the edge, sample #1 after it.
  task automatic step(input logic r, input logic ld, input logic [PW-1:0] p, input logic [LW-1:0] l,
                      input logic o, input logic clr, input logic v, input logic x);
    bit hit;
    reset = r; load = ld; pattern_in = p; length_in = l; overlap_in = o;
    count_clear = clr; input_valid = v; input_x = x;
    @(posedge clock);
    hit = 1'b0;
    if (r) begin
      m_pat = 8'b0001_0011; m_len = 5; m_ovl = 1'b1;
      q.delete(); exp_z = 1'b0; exp_cnt = 0;
    end else begin
      if (ld) begin
        m_pat = p;
        m_len = (l == 0 || int'(l) > PW) ? PW : int'(l);
        m_ovl = o;
        q.delete();
        exp_z = 1'b0;
      end else if (v) begin
        q.push_back(x);
        if (q.size() > PW) void'(q.pop_front());
        hit = (q.size() >= m_len);
        for (int i = 0; i < m_len && hit; i++)
          if (q[q.size() - m_len + i] != m_pat[m_len - 1 - i]) hit = 1'b0;
        exp_z = hit;
        if (hit && !m_ovl) q.delete();
      end else begin
        exp_z = 1'b0;
      end
      if (clr) exp_cnt = 0;
      if (hit && exp_cnt != (1 << CW) - 1) exp_cnt++;
    end
    #1;
  endtask

  task automatic test_reset;
    step(1, 0, '0, '0, 0, 0, 0, 0);
    n_cmp++;
    if (output_z !== 1'b0) begin n_bad++; $display("FAIL reset_z: got %b want 0", output_z); end
    n_cmp++;
    if (match_count !== 2'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", match_count); end
    n_cmp++;
    if (dut.fill !== 4'd0) begin n_bad++; $display("FAIL reset_fill: got %0d want 0", dut.fill); end
  endtask

  task automatic test_default_pattern;
    logic [4:0] bits = 5'b10011;
    logic [4:0] want = 5'b00001;
    for (int i = 0; i < 5; i++) begin
      step(0, 0, '0, '0, 0, 0, 1, bits[4-i]);
      n_cmp++;
      if (output_z !== want[4-i]) begin
        n_bad++; $display("FAIL default_z bit%0d: got %b want %b", i+1, output_z, want[4-i]);
      end
    end
    step(0, 0, '0, '0, 0, 0, 0, 0);
    n_cmp++;
    if (output_z !== 1'b0) begin n_bad++; $display("FAIL default_pulse_width: got %b want 0", output_z); end
    n_cmp++;
    if (match_count !== 2'd1) begin n_bad++; $display("FAIL default_count: got %0d want 1", match_count); end
  endtask

  task automatic test_overlap;
    logic [4:0] bits = 5'b10101;
    logic [4:0] want = 5'b00101;
    // Load cycle also asserts input_valid with x=1; that bit must be ignored.
    step(0, 1, 8'b101, 4'd3, 1, 1, 1, 1);
    n_cmp++;
    if (match_count !== 2'd0) begin n_bad++; $display("FAIL overlap_clear: got %0d want 0", match_count); end
    for (int i = 0; i < 5; i++) begin
      step(0, 0, '0, '0, 0, 0, 1, bits[4-i]);
      n_cmp++;
      if (output_z !== want[4-i]) begin
        n_bad++; $display("FAIL overlap_z bit%0d: got %b want %b", i+1, output_z, want[4-i]);
      end
    end
    n_cmp++;
    if (match_count !== 2'd2) begin n_bad++; $display("FAIL overlap_count: got %0d want 2", match_count); end
  endtask

  task automatic test_non_overlap;
    logic [5:0] bits = 6'b101101;
    logic [5:0] want = 6'b001001;
    step(0, 1, 8'b101, 4'd3, 0, 1, 0, 0);
    for (int i = 0; i < 6; i++) begin
      step(0, 0, '0, '0, 0, 0, 1, bits[5-i]);
      n_cmp++;
      if (output_z !== want[5-i]) begin
        n_bad++; $display("FAIL nonoverlap_z bit%0d: got %b want %b", i+1, output_z, want[5-i]);
      end
    end
    n_cmp++;
    if (match_count !== 2'd2) begin n_bad++; $display("FAIL nonoverlap_count: got %0d want 2", match_count); end
  endtask

  task automatic test_gaps_clamp;
    logic [7:0] bits = 8'hA5;
    int pulses = 0;
    step(0, 1, 8'hA5, 4'd0, 1, 1, 0, 0);
    for (int i = 0; i < 8; i++) begin
      step(0, 0, '0, '0, 0, 0, 1, bits[7-i]);
      n_cmp++;
      if (output_z !== (i == 7)) begin
        n_bad++; $display("FAIL gaps_z bit%0d: got %b want %b", i+1, output_z, (i == 7));
      end
      if (output_z === 1'b1) pulses++;
      step(0, 0, '0, '0, 0, 0, 0, 1);
      n_cmp++;
      if (output_z !== 1'b0) begin n_bad++; $display("FAIL gaps_idle_z gap%0d: got %b want 0", i+1, output_z); end
    end
    n_cmp++;
    if (pulses != 1) begin n_bad++; $display("FAIL gaps_pulses: got %0d want 1", pulses); end
    n_cmp++;
    if (match_count !== 2'd1) begin n_bad++; $display("FAIL gaps_count: got %0d want 1", match_count); end
  endtask

  task automatic test_saturation_clear;
    step(0, 1, 8'b1, 4'd1, 1, 1, 0, 0);
    for (int i = 0; i < 6; i++) begin
      step(0, 0, '0, '0, 0, 0, 1, 1);
      n_cmp++;
      if (match_count !== CW'((i < 3) ? i + 1 : 3)) begin
        n_bad++; $display("FAIL sat_count match%0d: got %0d want %0d", i+1, match_count, (i < 3) ? i + 1 : 3);
      end
    end
    step(0, 0, '0, '0, 0, 1, 1, 1);
    n_cmp++;
    if (match_count !== 2'd1) begin n_bad++; $display("FAIL clear_with_match: got %0d want 1", match_count); end
    n_cmp++;
    if (output_z !== 1'b1) begin n_bad++; $display("FAIL clear_with_match_z: got %b want 1", output_z); end
  endtask

  task automatic test_back_to_back;
    logic [3:0] want = 4'b0111;
    step(0, 1, 8'b11, 4'd2, 1, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, '0, '0, 0, 0, 1, 1);
      n_cmp++;
      if (output_z !== want[3-i]) begin
        n_bad++; $display("FAIL b2b_z bit%0d: got %b want %b", i+1, output_z, want[3-i]);
      end
    end
    n_cmp++;
    if (match_count !== 2'd3) begin n_bad++; $display("FAIL b2b_count: got %0d want 3", match_count); end
  endtask

  task automatic test_reset_midstream;
    logic [3:0] bits = 4'b1001;
    step(1, 0, '0, '0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, '0, '0, 0, 0, 1, bits[3-i]);
      n_cmp++;
      if (output_z !== 1'b0) begin n_bad++; $display("FAIL midrst_pre_z bit%0d: got %b want 0", i+1, output_z); end
    end
    step(1, 0, '0, '0, 0, 0, 1, 1);
    n_cmp++;
    if (dut.fill !== 4'd0) begin n_bad++; $display("FAIL midrst_fill: got %0d want 0", dut.fill); end
    step(0, 0, '0, '0, 0, 0, 1, 1);
    n_cmp++;
    if (output_z !== 1'b0) begin n_bad++; $display("FAIL midrst_z: got %b want 0", output_z); end
    n_cmp++;
    if (match_count !== 2'd0) begin n_bad++; $display("FAIL midrst_count: got %0d want 0", match_count); end
  endtask

  task automatic test_random;
    logic r, ld, o, clr, v, x;
    logic [PW-1:0] p;
    logic [LW-1:0] l;
    for (int c = 0; c < 1500; c++) begin
      r   = ($urandom_range(0, 99) == 0);
      ld  = ($urandom_range(0, 19) == 0);
      p   = PW'($urandom);
      l   = ($urandom_range(0, 2) == 0) ? LW'($urandom_range(0, 15)) : LW'($urandom_range(1, 3));
      o   = 1'($urandom);
      clr = ($urandom_range(0, 9) == 0);
      v   = ($urandom_range(0, 3) != 0);
      x   = 1'($urandom);
      step(r, ld, p, l, o, clr, v, x);
      n_cmp++;
      if (output_z !== exp_z) begin
        n_bad++; $display("FAIL rand_z cyc%0d: got %b want %b", c, output_z, exp_z);
      end
      n_cmp++;
      if (match_count !== CW'(exp_cnt)) begin
        n_bad++; $display("FAIL rand_count cyc%0d: got %0d want %0d", c, match_count, exp_cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_default_pattern();
    test_overlap();
    test_non_overlap();
    test_gaps_clamp();
    test_saturation_clear();
    test_back_to_back();
    test_reset_midstream();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/param_seq_detector.md
# param_seq_detector

Parametrised serial bit-pattern detector, the next generation of the fixed five-state Moore detector in the serial-protocol front end. It detects a runtime-loadable pattern of 1..PATTERN_W bits on a qualified serial stream and supports overlapping or non-overlapping matching. It produces a registered one-cycle match pulse and keeps a saturating match counter. It sits between the serial bit recovery stage and the frame-sync / control logic.

## Interface
- PATTERN_W, 8: maximum pattern length in bits (>= 2).
- COUNT_W, 8: width of the match counter.
- RESET_PATTERN, 8'b0001_0011: pattern loaded at reset, right-aligned (default detects 10011).
- RESET_LEN, 5: pattern length loaded at reset.
- RESET_OVERLAP, 1'b1: overlap mode loaded at reset.
- LEN_W (derived, not overridable) = $clog2(PATTERN_W+1).

Ports:
- clock  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; highest priority.
- load  in  1  capture pattern_in, length_in and overlap_in; clear history.
- pattern_in  in  PATTERN_W  pattern, right-aligned; bit [len-1] is the first bit received, bit [0] the last.
- length_in  in  LEN_W  active length; 0 or >PATTERN_W is clamped to PATTERN_W.
- overlap_in  in  1  1 = overlapping matches allowed, 0 = history restarts after a match.
- count_clear  in  1  clear match_count.
- input_valid  in  1  qualifies input_x for this cycle.
- input_x  in  1  serial data bit.
- output_z  out  1  registered match pulse.
- match_count  out  COUNT_W  saturating number of matches.

## Operation
- Internal state:
  - pattern register (pat), length register (len) and mode register (ovl);
  - history shift register hist[PATTERN_W-1:0], with the newest bit in bit 0;
  - fill counter fill, range 0..PATTERN_W, giving the number of valid history bits.
- Reset values:
  - pat = RESET_PATTERN, len = RESET_LEN (clamped), ovl = RESET_OVERLAP;
  - hist = 0, fill = 0, output_z = 0, match_count = 0.
- Per-edge priority is reset > load > input_valid.
- When load = 1:
  - pat, len (clamped) and ovl are captured; hist = 0, fill = 0, output_z = 0;
  - input_x is ignored that cycle;
  - match_count is unaffected.
- When input_valid = 1 and load = 0:
  - hist_n = {hist[PATTERN_W-2:0], input_x};
  - fill_n = min(fill+1, PATTERN_W);
  - a match requires fill_n >= len and hist_n[len-1:0] == pat[len-1:0], using a mask of the low len bits;
  - on a match: output_z <= 1, and match_count increments, saturating at 2^COUNT_W-1;
  - on a match with ovl = 1: fill <= fill_n;
  - on a match with ovl = 0: fill <= 0, so the next match needs len fresh bits;
  - with no match: output_z <= 0 and fill <= fill_n.
- When input_valid = 0: output_z <= 0; hist and fill hold.
- count_clear = 1 sets match_count to 0. If a match occurs in the same cycle, match_count becomes 1 (clear, then increment). A load in the same cycle does not block count_clear.
- Width rule: fill saturates at PATTERN_W; the comparison uses only the low len bits, and higher hist bits are don't-care.

## Timing
- Latency: output_z rises on the clock edge that samples the last pattern bit and is visible for exactly one cycle after that edge. This is Moore-style: the output is registered with no combinational path from input_x.
- match_count updates on the same edge as output_z.
- Back-to-back matches, with ovl = 1 and a pattern that self-overlaps (e.g. 11), keep output_z high on consecutive valid cycles.
- A load takes effect on the next edge. The first bit can be sampled on the cycle after load is deasserted.
- A reset mid-stream discards partial history; no spurious pulse follows reset.

## Test plan
- Default pattern after reset: stream 1,0,0,1,1 with input_valid = 1. output_z = 1 only in the cycle after the 5th bit; match_count = 1.
- Overlap mode: load pattern 101, len 3, overlap 1; stream 1,0,1,0,1. output_z pulses after bits 3 and 5; match_count = 2.
- Non-overlap mode: the same load with overlap 0; stream 1,0,1,1,0,1. output_z pulses after bits 3 and 6 only (none after bit 5); match_count = 2.
- Valid gaps and clamp: length_in = 0 with PATTERN_W = 8 and pattern 8'hA5; send the 8 bits with input_valid = 0 cycles between them. Exactly one one-cycle pulse follows the 8th valid bit.
- Saturation and clear: COUNT_W = 2, six matches give match_count = 3. count_clear asserted together with a 7th match gives match_count = 1.
- Reset mid-stream: send 1,0,0,1 with the default pattern, assert reset for one cycle, then send 1. No pulse; fill = 0 and match_count = 0.
